// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-memory access controller.
// Turns a registered load/store request into a req/ack bus handshake and stalls the pipeline until it completes.
module mem_access_ctrl #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          memwr,
  input  logic          memrd,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_ack,
  input  logic [DW-1:0] bus_rdata,
  output logic          stall,
  output logic [DW-1:0] rdata,
  output logic          rdata_valid,
  output logic          bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic          req;
  logic          aligned;
  logic          last;

  assign req     = memrd | memwr;
  assign aligned = (addr[1:0] == 2'b00);
  assign last    = (count == CNT_LAST);

  // Stall drops in the final BUSY cycle (ack or timeout) so the instruction reaches WB with its result.
  assign stall = ((state == IDLE) & req & aligned) |
                 ((state == BUSY) & ~bus_ack & ~last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      bus_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (aligned) begin
              bus_addr  <= addr;
              bus_wdata <= wdata;
              bus_we    <= memwr;
              bus_req   <= 1'b1;
              count     <= '0;
              state     <= BUSY;
            end else begin
              bus_err <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            state   <= IDLE;
            if (!bus_we) begin
              rdata       <= bus_rdata;
              rdata_valid <= 1'b1;
            end
          end else if (last) begin
            bus_req <= 1'b0;
            bus_err <= 1'b1;
            state   <= IDLE;
          end else if (count != CNT_MAX) begin
            count <= count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
